ring_inject_buffer: RTL and testbench

- Per-node injection stage directly upstream of the ring interconnect.
- Accepts packets from each core/cache port with a valid/ready handshake and queues them in a per-node FIFO.
- Drives the ring's per-node packet and one-cycle core-injection strobe only while that ring node is not full.
- Tracks in-flight packets by counting injections against ring delivery pulses.

---
 rtl/ring_inject_buffer_pkg.sv | 20 ++
 rtl/ring_inject_buffer_if.sv | 29 ++
 rtl/ring_inject_buffer_fifo.sv | 62 ++++++
 rtl/ring_inject_buffer.sv | 125 ++++++++++++
 tb/tb_ring_inject_buffer.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ring_inject_buffer_pkg.sv
// Shared types for the ring injection stage: lane count, node id width, packet format.
// Packet legality is defined here so every lane applies the same rule.
package ring_inject_buffer_pkg;

    localparam int NUM_NODES = 4;
    localparam int NODE_W    = $clog2(NUM_NODES);

    typedef logic [NUM_NODES-1:0] lane_vec_t;

    typedef struct packed {
        logic [NODE_W-1:0] src;
        logic [NODE_W-1:0] dest;
    } pkt_t;

    // A packet must target an existing node other than itself and originate from its own lane.
    function automatic logic pkt_ok(pkt_t p, int lane);
        return (int'(p.dest) < NUM_NODES) && (p.dest != p.src) && (int'(p.src) == lane);
    endfunction

endpackage

// File: rtl/ring_inject_buffer_if.sv
// Core-side request bus and ring-side injection bus of the injection stage.
// slave is the buffer's view, master is the driver/observer's view.
interface ring_inject_buffer_if #(
    parameter int CNT_W = 8
);
    import ring_inject_buffer_pkg::*;

    lane_vec_t                     core_valid;
    pkt_t [NUM_NODES-1:0]          core_pkt;
    lane_vec_t                     core_ready;
    lane_vec_t                     ring_full;
    pkt_t [NUM_NODES-1:0]          ring_pkt;
    lane_vec_t                     ring_pkt_valid;
    lane_vec_t                     ring_recieved;
    logic [CNT_W-1:0]              inflight;
    logic                          err;
    logic [NUM_NODES-1:0][15:0]    stall_cnt;

    modport slave (
        input  core_valid, core_pkt, ring_full, ring_recieved,
        output core_ready, ring_pkt, ring_pkt_valid, inflight, err, stall_cnt
    );

    modport master (
        output core_valid, core_pkt, ring_full, ring_recieved,
        input  core_ready, ring_pkt, ring_pkt_valid, inflight, err, stall_cnt
    );

endinterface

// File: rtl/ring_inject_buffer_fifo.sv
// Single-lane packet FIFO; head is valid whenever count is non-zero.
// Caller guarantees no push when full and no pop when empty.
module inject_fifo
    import ring_inject_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  pkt_t                   push_dat,
    input  logic                   pop,
    output pkt_t                   head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    pkt_t             mem_q [DEPTH];
    pkt_t             mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/ring_inject_buffer.sv
// Per-node injection stage: lane FIFOs feeding registered one-cycle ring strobes, in-flight tracking.
// Optional INJECT_STATS_EN adds per-lane saturating stall counters; otherwise stall_cnt reads 0.
module ring_inject_buffer
    import ring_inject_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    ring_inject_buffer_if.slave  bus
);
    localparam int CW      = $clog2(DEPTH) + 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic [CW-1:0]        count [NUM_NODES];
    pkt_t                 head  [NUM_NODES];
    lane_vec_t            ready, push_fire, store, bad_pkt, pop;
    logic                 init_q, init_d;
    pkt_t [NUM_NODES-1:0] ring_pkt_q, ring_pkt_d;
    lane_vec_t            ring_pkt_valid_q, ring_pkt_valid_d;
    logic [CNT_W-1:0]     inflight_q, inflight_d;
    logic                 err_q, err_d;
    int                   inflight_sum;

    // init_q keeps core_ready low through reset and for the first cycle afterwards.
    assign init_d = 1'b1;

    always_comb begin
        ready     = '0;
        push_fire = '0;
        store     = '0;
        bad_pkt   = '0;
        pop       = '0;
        for (int i = 0; i < NUM_NODES; i++) begin
            ready[i]     = init_q && (count[i] != CW'(DEPTH));
            push_fire[i] = bus.core_valid[i] && ready[i];
            store[i]     = push_fire[i] && pkt_ok(bus.core_pkt[i], i);
            bad_pkt[i]   = push_fire[i] && !pkt_ok(bus.core_pkt[i], i);
            pop[i]       = (count[i] != '0) && !bus.ring_full[i];
        end
    end

    for (genvar g = 0; g < NUM_NODES; g++) begin : g_lane
        inject_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (store[g]),
            .push_dat (bus.core_pkt[g]),
            .pop      (pop[g]),
            .head     (head[g]),
            .count    (count[g])
        );
    end

    always_comb begin
        ring_pkt_d       = '0;
        ring_pkt_valid_d = '0;
        err_d            = err_q || (|bad_pkt);
        for (int i = 0; i < NUM_NODES; i++) begin
            if (pop[i]) begin
                ring_pkt_d[i]       = head[i];
                ring_pkt_valid_d[i] = 1'b1;
            end
        end
        inflight_sum = int'(inflight_q) + $countones(pop) - $countones(bus.ring_recieved);
        if (inflight_sum < 0) begin
            inflight_d = '0;
            err_d      = 1'b1;
        end else if (inflight_sum > CNT_MAX) begin
            inflight_d = CNT_W'(CNT_MAX);
            err_d      = 1'b1;
        end else begin
            inflight_d = CNT_W'(inflight_sum);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q           <= 1'b0;
            ring_pkt_q       <= '0;
            ring_pkt_valid_q <= '0;
            inflight_q       <= '0;
            err_q            <= 1'b0;
        end else begin
            init_q           <= init_d;
            ring_pkt_q       <= ring_pkt_d;
            ring_pkt_valid_q <= ring_pkt_valid_d;
            inflight_q       <= inflight_d;
            err_q            <= err_d;
        end
    end

    assign bus.core_ready     = ready;
    assign bus.ring_pkt       = ring_pkt_q;
    assign bus.ring_pkt_valid = ring_pkt_valid_q;
    assign bus.inflight       = inflight_q;
    assign bus.err            = err_q;

`ifdef INJECT_STATS_EN
    logic [NUM_NODES-1:0][15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        for (int i = 0; i < NUM_NODES; i++) begin
            if ((count[i] != '0) && bus.ring_full[i] && (stall_cnt_q[i] != 16'hFFFF)) begin
                stall_cnt_d[i] = stall_cnt_q[i] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ring_inject_buffer.sv
// Directed self-checking bench for ring_inject_buffer; inputs and samples both taken 1ns after the rising edge.
module tb_ring_inject_buffer;
    import ring_inject_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   want_stall;

    always #5 clk = ~clk;

    ring_inject_buffer_if #(.CNT_W(8)) bus ();

    ring_inject_buffer #(.DEPTH(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic pkt_t mk(int s, int d);
        pkt_t p;
        p.src  = NODE_W'(s);
        p.dest = NODE_W'(d);
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.core_valid    = '0;
        bus.core_pkt      = '0;
        bus.ring_full     = '0;
        bus.ring_recieved = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        total++;
        if (bus.core_ready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_ready_low got=%b want=0000", bus.core_ready);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (bus.core_ready !== 4'b1111) begin
            bad++;
            $display("FAIL rst_ready got=%b want=1111", bus.core_ready);
        end
        total++;
        if (bus.ring_pkt_valid !== 4'b0000 || bus.ring_pkt !== '0) begin
            bad++;
            $display("FAIL rst_ring got_vld=%b got_pkt=%h want=0", bus.ring_pkt_valid, bus.ring_pkt);
        end
        total++;
        if (bus.inflight !== 8'd0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL rst_cnt got_inflight=%0d got_err=%b want=0/0", bus.inflight, bus.err);
        end
        total++;
        if (bus.stall_cnt !== '0) begin
            bad++;
            $display("FAIL rst_stall got=%h want=0", bus.stall_cnt);
        end
    endtask

    task automatic test_single();
        bus.core_valid  = 4'b0010;
        bus.core_pkt[1] = mk(1, 3);
        tick();
        bus.core_valid = '0;
        total++;
        if (bus.ring_pkt_valid !== 4'b0000) begin
            bad++;
            $display("FAIL single_no_bypass got=%b want=0000", bus.ring_pkt_valid);
        end
        tick();
        total++;
        if (bus.ring_pkt_valid !== 4'b0010 || bus.ring_pkt[1] !== mk(1, 3)) begin
            bad++;
            $display("FAIL single_inject got_vld=%b got_pkt=%h want=0010/%h",
                     bus.ring_pkt_valid, bus.ring_pkt[1], mk(1, 3));
        end
        total++;
        if (bus.inflight !== 8'd1) begin
            bad++;
            $display("FAIL single_inflight got=%0d want=1", bus.inflight);
        end
        tick();
        total++;
        if (bus.ring_pkt_valid !== 4'b0000 || bus.ring_pkt !== '0) begin
            bad++;
            $display("FAIL single_one_cycle got_vld=%b got_pkt=%h want=0", bus.ring_pkt_valid, bus.ring_pkt);
        end
        bus.ring_recieved = 4'b1000;
        tick();
        bus.ring_recieved = '0;
        total++;
        if (bus.inflight !== 8'd0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL single_deliver got_inflight=%0d got_err=%b want=0/0", bus.inflight, bus.err);
        end
    endtask

    task automatic test_backpressure();
        pkt_t exp_q [4];
        bus.ring_full = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            bus.core_valid  = 4'b0001;
            bus.core_pkt[0] = mk(0, 1 + (k % 3));
            if (k < 4) exp_q[k] = mk(0, 1 + (k % 3));
            tick();
            total++;
            if (bus.ring_pkt_valid !== 4'b0000) begin
                bad++;
                $display("FAIL bp_no_inject k=%0d got=%b want=0000", k, bus.ring_pkt_valid);
            end
            if (k >= 3) begin
                total++;
                if (bus.core_ready !== 4'b1110) begin
                    bad++;
                    $display("FAIL bp_full_ready k=%0d got=%b want=1110", k, bus.core_ready);
                end
            end
        end
        bus.core_valid = '0;
`ifdef INJECT_STATS_EN
        want_stall = 4;
`else
        want_stall = 0;
`endif
        total++;
        if (bus.stall_cnt[0] !== 16'(want_stall)) begin
            bad++;
            $display("FAIL bp_stall got=%0d want=%0d", bus.stall_cnt[0], want_stall);
        end
        bus.ring_full = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bus.ring_pkt_valid !== 4'b0001 || bus.ring_pkt[0] !== exp_q[k]) begin
                bad++;
                $display("FAIL bp_drain k=%0d got_vld=%b got_pkt=%h want=0001/%h",
                         k, bus.ring_pkt_valid, bus.ring_pkt[0], exp_q[k]);
            end
        end
        tick();
        total++;
        if (bus.ring_pkt_valid !== 4'b0000 || bus.inflight !== 8'd4) begin
            bad++;
            $display("FAIL bp_after got_vld=%b got_inflight=%0d want=0000/4", bus.ring_pkt_valid, bus.inflight);
        end
        bus.ring_recieved = 4'b1111;
        tick();
        bus.ring_recieved = '0;
        total++;
        if (bus.inflight !== 8'd0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL bp_deliver got_inflight=%0d got_err=%b want=0/0", bus.inflight, bus.err);
        end
    endtask

    task automatic test_back_to_back();
        int dtab [3] = '{0, 2, 3};
        for (int n = 0; n < 12; n++) begin
            bus.core_valid  = (n < 10) ? 4'b0010 : 4'b0000;
            bus.core_pkt[1] = mk(1, dtab[n % 3]);
            bus.ring_full   = (n < 2) ? 4'b0010 : 4'b0000;
            tick();
            total++;
            if (n >= 2) begin
                if (bus.ring_pkt_valid !== 4'b0010 || bus.ring_pkt[1] !== mk(1, dtab[(n - 2) % 3])) begin
                    bad++;
                    $display("FAIL b2b_order n=%0d got_vld=%b got_pkt=%h want=0010/%h",
                             n, bus.ring_pkt_valid, bus.ring_pkt[1], mk(1, dtab[(n - 2) % 3]));
                end
            end else if (bus.ring_pkt_valid !== 4'b0000) begin
                bad++;
                $display("FAIL b2b_hold n=%0d got=%b want=0000", n, bus.ring_pkt_valid);
            end
            total++;
            if (bus.core_ready !== 4'b1111) begin
                bad++;
                $display("FAIL b2b_ready n=%0d got=%b want=1111", n, bus.core_ready);
            end
        end
        idle_inputs();
        tick();
        total++;
        if (bus.ring_pkt_valid !== 4'b0000 || bus.inflight !== 8'd10) begin
            bad++;
            $display("FAIL b2b_end got_vld=%b got_inflight=%0d want=0000/10", bus.ring_pkt_valid, bus.inflight);
        end
        bus.ring_recieved = 4'b1111;
        tick();
        tick();
        bus.ring_recieved = 4'b0011;
        tick();
        bus.ring_recieved = '0;
        total++;
        if (bus.inflight !== 8'd0 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_deliver got_inflight=%0d got_err=%b want=0/0", bus.inflight, bus.err);
        end
    endtask

    task automatic test_illegal();
        bus.core_valid  = 4'b0100;
        bus.core_pkt[2] = mk(2, 2);
        tick();
        bus.core_valid = '0;
        total++;
        if (bus.err !== 1'b1 || bus.core_ready !== 4'b1111) begin
            bad++;
            $display("FAIL illegal_err got_err=%b got_ready=%b want=1/1111", bus.err, bus.core_ready);
        end
        bus.core_valid  = 4'b1000;
        bus.core_pkt[3] = mk(1, 2);
        tick();
        bus.core_valid = '0;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (bus.ring_pkt_valid !== 4'b0000) begin
                bad++;
                $display("FAIL illegal_dropped k=%0d got=%b want=0000", k, bus.ring_pkt_valid);
            end
            tick();
        end
        bus.ring_recieved = 4'b0100;
        tick();
        bus.ring_recieved = '0;
        total++;
        if (bus.inflight !== 8'd0 || bus.err !== 1'b1) begin
            bad++;
            $display("FAIL underflow got_inflight=%0d got_err=%b want=0/1", bus.inflight, bus.err);
        end
    endtask

    task automatic test_reset_mid();
        bus.ring_full = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            bus.core_valid  = 4'b1000;
            bus.core_pkt[3] = mk(3, k);
            tick();
        end
        bus.core_valid = '0;
        rst            = 1'b1;
        bus.ring_full  = '0;
        tick();
        total++;
        if (bus.ring_pkt_valid !== 4'b0000 || bus.core_ready !== 4'b0000 || bus.err !== 1'b0) begin
            bad++;
            $display("FAIL midrst_in got_vld=%b got_ready=%b got_err=%b want=0000/0000/0",
                     bus.ring_pkt_valid, bus.core_ready, bus.err);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++;
            if (bus.ring_pkt_valid !== 4'b0000) begin
                bad++;
                $display("FAIL midrst_no_inject k=%0d got=%b want=0000", k, bus.ring_pkt_valid);
            end
        end
        total++;
        if (bus.core_ready !== 4'b1111 || bus.inflight !== 8'd0 || bus.stall_cnt !== '0) begin
            bad++;
            $display("FAIL midrst_after got_ready=%b got_inflight=%0d got_stall=%h want=1111/0/0",
                     bus.core_ready, bus.inflight, bus.stall_cnt);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
